// File: rtl/operand_sequencer.sv
// Operand sequencer: fetches register operands for a downstream ALU, steps a
// six-state command FSM, and writes results back into an eight-entry register file.
module operand_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [2:0]  opcode,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [7:0]  imm8,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic [2:0]  alu_z,
    output logic        w,
    output logic [2:0]  status,
    output logic        err,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_WRITE
    } state_t;

    typedef enum logic [2:0] {
        OP_MOVI = 3'b000,
        OP_MOV  = 3'b001,
        OP_ADD  = 3'b010,
        OP_CMP  = 3'b011,
        OP_AND  = 3'b100,
        OP_MVN  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } opcode_t;

    typedef struct packed {
        opcode_t    op;
        logic [2:0] rd;
        logic [2:0] rn;
        logic [2:0] rm;
        logic [7:0] imm8;
    } instr_t;

    state_t      state;
    state_t      state_next;
    instr_t      ir;
    logic [15:0] regs [8];
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] c_reg;
    logic [15:0] write_data;

    logic load_ir;
    logic load_a;
    logic load_b;
    logic load_c;
    logic load_status;
    logic write_reg;
    logic err_next;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        load_ir     = 1'b0;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_c      = 1'b0;
        load_status = 1'b0;
        write_reg   = 1'b0;
        err_next    = 1'b0;

        case (state)
            ST_WAIT: begin
                if (s) begin
                    load_ir    = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (ir.op)
                    OP_ADD, OP_CMP, OP_AND: state_next = ST_GET_A;
                    OP_MOV, OP_MVN:         state_next = ST_GET_B;
                    OP_MOVI:                state_next = ST_WRITE;
                    default: begin
                        state_next = ST_WAIT;
                        err_next   = 1'b1;
                    end
                endcase
            end
            ST_GET_A: begin
                load_a     = 1'b1;
                state_next = ST_GET_B;
            end
            ST_GET_B: begin
                load_b     = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (ir.op == OP_CMP) begin
                    load_status = 1'b1;
                    state_next  = ST_WAIT;
                end else begin
                    load_c     = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                write_reg  = 1'b1;
                state_next = ST_WAIT;
            end
            default: state_next = ST_WAIT;
        endcase

        // A start arriving while busy is dropped, never queued.
        if (s && (state != ST_WAIT)) begin
            err_next = 1'b1;
        end
    end

    always_comb begin
        alu_op = 2'b00;
        case (ir.op)
            OP_CMP:  alu_op = 2'b01;
            OP_AND:  alu_op = 2'b10;
            OP_MVN:  alu_op = 2'b11;
            default: alu_op = 2'b00;
        endcase
    end

    assign alu_a      = (ir.op == OP_MOV) ? 16'h0000 : a_reg;
    assign alu_b      = b_reg;
    assign w          = (state == ST_WAIT);
    assign dbg_data   = regs[dbg_sel];
    assign write_data = (ir.op == OP_MOVI) ? {{8{ir.imm8[7]}}, ir.imm8} : c_reg;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_WAIT;
            err    <= 1'b0;
            ir     <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            c_reg  <= '0;
            status <= '0;
            // NOTE: the register file is small and must read zero after reset,
            // so it is built from flops rather than an unresettable RAM.
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            err   <= err_next;
            if (load_ir) begin
                ir.op   <= opcode_t'(opcode);
                ir.rd   <= rd;
                ir.rn   <= rn;
                ir.rm   <= rm;
                ir.imm8 <= imm8;
            end
            if (load_a) begin
                a_reg <= regs[ir.rn];
            end
            if (load_b) begin
                b_reg <= regs[ir.rm];
            end
            if (load_c) begin
                c_reg <= alu_out;
            end
            if (load_status) begin
                status <= alu_z;
            end
            if (write_reg) begin
                regs[ir.rd] <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed vector table, randomized commands against
// an arithmetic reference model, and hand sequences for busy-start and mid-command reset.
module tb_operand_sequencer;

    logic        clk;
    logic        reset;
    logic        s;
    logic [2:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [7:0]  imm8;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic [2:0]  alu_z;
    logic        w;
    logic [2:0]  status;
    logic        err;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    localparam int LIMIT = 20;

    operand_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .opcode   (opcode),
        .rd       (rd),
        .rn       (rn),
        .rm       (rm),
        .imm8     (imm8),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_z    (alu_z),
        .w        (w),
        .status   (status),
        .err      (err),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Downstream ALU: combinational, flags are {negative, overflow, zero}.
    logic [15:0] alu_res;
    logic        alu_v;
    always_comb begin
        alu_res = 16'h0000;
        alu_v   = 1'b0;
        case (alu_op)
            2'b00: begin
                alu_res = alu_a + alu_b;
                alu_v   = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            2'b01: begin
                alu_res = alu_a - alu_b;
                alu_v   = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            2'b10:   alu_res = alu_a & alu_b;
            default: alu_res = ~alu_b;
        endcase
    end
    assign alu_out = alu_res;
    assign alu_z   = {alu_res[15], alu_v, (alu_res == 16'h0000)};

    // Reference model: register values as plain integers in 0..65535.
    int         m_r [8];
    logic [2:0] m_status;

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int model_apply(input logic [2:0] op, input logic [2:0] rd_i,
                                       input logic [2:0] rn_i, input logic [2:0] rm_i,
                                       input logic [7:0] imm_i);
        int a_v;
        int b_v;
        int d;
        a_v = m_r[rn_i];
        b_v = m_r[rm_i];
        case (op)
            3'd0: begin
                m_r[rd_i] = int'(imm_i) + (imm_i[7] ? 65280 : 0);
                return 2;
            end
            3'd1: begin
                m_r[rd_i] = b_v;
                return 4;
            end
            3'd2: begin
                m_r[rd_i] = (a_v + b_v) % 65536;
                return 5;
            end
            3'd3: begin
                d = to_signed16(a_v) - to_signed16(b_v);
                m_status[0] = (a_v == b_v);
                m_status[1] = (d > 32767) || (d < -32768);
                m_status[2] = (((a_v - b_v) + 65536) % 65536) >= 32768;
                return 4;
            end
            3'd4: begin
                m_r[rd_i] = a_v & b_v;
                return 5;
            end
            3'd5: begin
                m_r[rd_i] = 65535 - b_v;
                return 4;
            end
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check($sformatf("%s_R%0d", tag, i), {16'h0, dbg_data}, m_r[i]);
        end
        check($sformatf("%s_status", tag), {29'h0, status}, {29'h0, m_status});
    endtask

    // Issue one command; returns edges after the capturing edge until w=1, and
    // the number of cycles err was seen high over the command plus one idle cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd_i, input logic [2:0] rn_i,
                         input logic [2:0] rm_i, input logic [7:0] imm_i,
                         output int lat, output int errs);
        @(negedge clk);
        opcode = op;
        rd     = rd_i;
        rn     = rn_i;
        rm     = rm_i;
        imm8   = imm_i;
        s      = 1'b1;
        @(negedge clk);
        s    = 1'b0;
        lat  = 0;
        errs = int'(err);
        while (!w && lat < LIMIT) begin
            @(negedge clk);
            lat++;
            errs += int'(err);
        end
        @(negedge clk);
        errs += int'(err);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [7:0]  imm;
        int          lat;
        int          errs;
        logic [15:0] rd_val;
        logic [2:0]  st;
    } vec_t;

    vec_t       vecs [18];
    int         lat;
    int         errs;
    int         exp_lat;
    logic [2:0] r_op;
    logic [2:0] r_rd;
    logic [2:0] r_rn;
    logic [2:0] r_rm;
    logic [7:0] r_imm;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            op    rd    rn    rm    imm    lat errs rd_val    st
        vecs[0]  = '{3'd0, 3'd1, 3'd0, 3'd0, 8'hFE, 2, 0, 16'hFFFE, 3'b000};
        vecs[1]  = '{3'd0, 3'd1, 3'd0, 3'd0, 8'h03, 2, 0, 16'h0003, 3'b000};
        vecs[2]  = '{3'd0, 3'd2, 3'd0, 3'd0, 8'h05, 2, 0, 16'h0005, 3'b000};
        vecs[3]  = '{3'd2, 3'd3, 3'd1, 3'd2, 8'h00, 5, 0, 16'h0008, 3'b000};
        vecs[4]  = '{3'd0, 3'd1, 3'd0, 3'd0, 8'h07, 2, 0, 16'h0007, 3'b000};
        vecs[5]  = '{3'd0, 3'd2, 3'd0, 3'd0, 8'h07, 2, 0, 16'h0007, 3'b000};
        vecs[6]  = '{3'd3, 3'd6, 3'd1, 3'd2, 8'h00, 4, 0, 16'h0000, 3'b001};
        vecs[7]  = '{3'd5, 3'd4, 3'd0, 3'd0, 8'h00, 4, 0, 16'hFFFF, 3'b001};
        vecs[8]  = '{3'd1, 3'd5, 3'd0, 3'd4, 8'h00, 4, 0, 16'hFFFF, 3'b001};
        vecs[9]  = '{3'd6, 3'd7, 3'd1, 3'd2, 8'h00, 1, 1, 16'h0000, 3'b001};
        vecs[10] = '{3'd7, 3'd3, 3'd1, 3'd2, 8'h00, 1, 1, 16'h0008, 3'b001};
        vecs[11] = '{3'd2, 3'd1, 3'd1, 3'd1, 8'h00, 5, 0, 16'h000E, 3'b001};
        vecs[12] = '{3'd4, 3'd2, 3'd4, 3'd1, 8'h00, 5, 0, 16'h000E, 3'b001};
        vecs[13] = '{3'd3, 3'd0, 3'd3, 3'd1, 8'h00, 4, 0, 16'h0000, 3'b100};
        vecs[14] = '{3'd0, 3'd0, 3'd0, 3'd0, 8'h80, 2, 0, 16'hFF80, 3'b100};
        vecs[15] = '{3'd1, 3'd6, 3'd0, 3'd3, 8'h00, 4, 0, 16'h0008, 3'b100};
        vecs[16] = '{3'd3, 3'd0, 3'd5, 3'd0, 8'h00, 4, 0, 16'hFF80, 3'b000};
        vecs[17] = '{3'd2, 3'd7, 3'd0, 3'd0, 8'h00, 5, 0, 16'hFF00, 3'b000};

        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_status = 3'b000;

        reset = 1'b1;
        s = 1'b0; opcode = 3'd0; rd = 3'd0; rn = 3'd0; rm = 3'd0; imm8 = 8'h00; dbg_sel = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_w", {31'h0, w}, 32'd1);
        check("reset_err", {31'h0, err}, 32'd0);
        check("reset_alu_a", {16'h0, alu_a}, 32'h0);
        check("reset_alu_b", {16'h0, alu_b}, 32'h0);
        check("reset_alu_op", {30'h0, alu_op}, 32'h0);
        check_regs("reset");

        for (int i = 0; i < 18; i++) begin
            exp_lat = model_apply(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
            issue(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, lat, errs);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_err", i), errs, vecs[i].errs);
            dbg_sel = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_rd", i), {16'h0, dbg_data}, {16'h0, vecs[i].rd_val});
            check($sformatf("vec%0d_st", i), {29'h0, status}, {29'h0, vecs[i].st});
            check($sformatf("vec%0d_model_lat", i), exp_lat, vecs[i].lat);
            check_regs($sformatf("vec%0d", i));
        end

        for (int n = 0; n < 200; n++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_rd  = 3'($urandom_range(0, 7));
            r_rn  = 3'($urandom_range(0, 7));
            r_rm  = 3'($urandom_range(0, 7));
            r_imm = 8'($urandom_range(0, 255));
            exp_lat = model_apply(r_op, r_rd, r_rn, r_rm, r_imm);
            issue(r_op, r_rd, r_rn, r_rm, r_imm, lat, errs);
            check($sformatf("rnd%0d_op%0d_lat", n, r_op), lat, exp_lat);
            check($sformatf("rnd%0d_op%0d_err", n, r_op), errs, (r_op >= 3'd6) ? 1 : 0);
            check_regs($sformatf("rnd%0d", n));
        end

        // Start while busy: ADD R7 = R3 + R2 with a MOVI R6 strobe arriving in GET_A.
        @(negedge clk);
        opcode = 3'd2; rd = 3'd7; rn = 3'd3; rm = 3'd2; imm8 = 8'h00; s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        opcode = 3'd0; rd = 3'd6; imm8 = 8'h11; s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        check("busy_err_pulse", {31'h0, err}, 32'd1);
        @(negedge clk);
        check("busy_err_width", {31'h0, err}, 32'd0);
        lat = 3;
        while (!w && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        check("busy_lat", lat, 5);
        exp_lat = model_apply(3'd2, 3'd7, 3'd3, 3'd2, 8'h00);
        @(negedge clk);
        check("busy_not_queued", {31'h0, w}, 32'd1);
        check_regs("busy");

        // Reset in EXEC of an ADD, with a start strobe sampled on the reset edge.
        @(negedge clk);
        opcode = 3'd2; rd = 3'd1; rn = 3'd1; rm = 3'd2; s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; s = 1'b1; opcode = 3'd0; rd = 3'd2; imm8 = 8'h55;
        @(negedge clk);
        reset = 1'b0; s = 1'b0;
        check("rst_mid_w", {31'h0, w}, 32'd1);
        check("rst_mid_err", {31'h0, err}, 32'd0);
        check("rst_mid_alu_a", {16'h0, alu_a}, 32'h0);
        check("rst_mid_alu_b", {16'h0, alu_b}, 32'h0);
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_status = 3'b000;
        check_regs("rst_mid");
        @(negedge clk);
        check("rst_start_discarded", {31'h0, w}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
